// File: rtl/feature_readout.sv
// Feature readout: collects one frame of scattered feature writes, then streams
// it out in index order with a handshake while tracking the argmax.
package graph_pkg;
    localparam int PRECISION = 16;
endpackage

module feature_readout #(
    parameter int NUM_ENTRIES = 64,
    parameter int PRECISION   = graph_pkg::PRECISION,
    localparam int ADDR_W     = $clog2(NUM_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [PRECISION-1:0] in_data,
    input  logic                 in_valid,
    output logic [PRECISION-1:0] m_data,
    output logic [ADDR_W-1:0]    m_idx,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ADDR_W-1:0]    argmax_idx,
    output logic                 argmax_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                      state;
    logic signed [PRECISION-1:0] buffer [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]      written;
    logic [ADDR_W:0]             count;
    logic signed [PRECISION-1:0] max_val;
    logic [ADDR_W-1:0]           max_idx;
    logic signed [PRECISION-1:0] beat_data;
    logic [31:0]                 addr_ext;
    logic                        addr_ok;
    logic                        wr_en;
    logic                        wr_new;
    logic                        frame_done;
    logic                        hs;
    logic                        take_max;
    logic [ADDR_W-1:0]           next_idx;

    // Strict greater-than keeps the earlier (lower) index on ties.
    function automatic logic is_new_max(input logic signed [PRECISION-1:0] cand,
                                        input logic signed [PRECISION-1:0] best,
                                        input logic                        first);
        return first || (cand > best);
    endfunction

    assign addr_ext   = 32'(in_addr);
    assign addr_ok    = addr_ext < 32'(NUM_ENTRIES);
    assign wr_en      = (state == COLLECT) && in_valid && addr_ok;
    assign wr_new     = wr_en && !written[in_addr];
    assign frame_done = wr_new && (count == (ADDR_W+1)'(NUM_ENTRIES - 1));
    assign hs         = m_valid && m_ready;
    assign beat_data  = m_data;
    assign take_max   = is_new_max(beat_data, max_val, m_idx == '0);
    assign next_idx   = m_idx + ADDR_W'(1);

    // Feature storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[in_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= COLLECT;
            written      <= '0;
            count        <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_data       <= '0;
            m_idx        <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            max_val      <= '0;
            max_idx      <= '0;
        end else begin
            argmax_valid <= 1'b0;
            if (in_valid && ((state == DRAIN) || !addr_ok)) begin
                overrun <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (wr_en) begin
                        written[in_addr] <= 1'b1;
                        if (wr_new) begin
                            count <= count + (ADDR_W+1)'(1);
                        end
                    end
                    if (frame_done) begin
                        state   <= DRAIN;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        m_idx   <= '0;
                        m_last  <= 1'b0;
                        // Entry 0 may be the very write that completes the frame.
                        m_data  <= (in_addr == '0) ? in_data : buffer[0];
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (take_max) begin
                            max_val <= beat_data;
                            max_idx <= m_idx;
                        end
                        if (m_last) begin
                            state        <= COLLECT;
                            busy         <= 1'b0;
                            m_valid      <= 1'b0;
                            m_last       <= 1'b0;
                            written      <= '0;
                            count        <= '0;
                            argmax_valid <= 1'b1;
                            argmax_idx   <= take_max ? m_idx : max_idx;
                        end else begin
                            m_idx  <= next_idx;
                            m_data <= buffer[next_idx];
                            m_last <= (next_idx == ADDR_W'(NUM_ENTRIES - 1));
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_readout.sv
// Scoreboard bench for feature_readout: frame model pushes expected beats and
// argmax on frame completion; a negedge monitor pops and compares.
module tb_feature_readout;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  in_addr = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] m_data;
    logic [5:0]  m_idx;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [5:0]  argmax_idx;
    logic        argmax_valid;
    logic        busy;
    logic        overrun;

    feature_readout dut (
        .clk          (clk),
        .reset        (reset),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .m_data       (m_data),
        .m_idx        (m_idx),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    beat_t beat_q[$];
    int    am_q[$];
    int    mbuf[N];
    bit    mw[N];
    int    mcount = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    hs_count = 0;
    int    last_am = 0;
    bit    stall_prev = 0;
    logic [15:0] held_data;
    logic [5:0]  held_idx;
    logic        held_last;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: stability while stalled, beats and argmax against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_data", $signed(m_data), $signed(held_data));
                check("hold_idx", m_idx, held_idx);
                check("hold_last", m_last, held_last);
            end
            if (m_valid && m_ready) begin
                hs_count++;
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_idx", m_idx, b.idx);
                    check("beat_data", $signed(m_data), b.data);
                    check("beat_last", m_last, b.last);
                end
            end
            if (argmax_valid) begin
                if (am_q.size() == 0) begin
                    check("unexpected_argmax", 1, 0);
                end else begin
                    last_am = am_q.pop_front();
                    check("argmax_idx", argmax_idx, last_am);
                end
            end
            stall_prev = m_valid && !m_ready;
            held_data  = m_data;
            held_idx   = m_idx;
            held_last  = m_last;
        end
    end

    task automatic tb_write(input int addr, input int data);
        bit done = 0;
        if (!mw[addr]) mcount++;
        mw[addr]   = 1;
        mbuf[addr] = data;
        if (mcount == N) begin
            int best = 0;
            for (int i = 0; i < N; i++) begin
                beat_q.push_back('{i, mbuf[i], i == N - 1});
                if (mbuf[i] > mbuf[best]) best = i;
            end
            am_q.push_back(best);
            for (int i = 0; i < N; i++) mw[i] = 0;
            mcount = 0;
            done   = 1;
        end
        in_valid = 1'b1;
        in_addr  = addr[5:0];
        in_data  = data[15:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_write", busy, done);
        if (done) check("first_idx", m_idx, 0);
    endtask

    task automatic run_drain(input bit toggle, input bit inject, input int rst_beat);
        int cyc = 0;
        bit done = 0;
        hs_count = 0;
        while (!done && cyc < 1000) begin
            m_ready  = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid = 1'b0;
            if (inject && (cyc == 3 || (m_valid && m_ready && m_last))) begin
                in_valid = 1'b1;
                in_addr  = (cyc == 3) ? 6'd2 : 6'd7;
                in_data  = 16'd999;
            end
            if (rst_beat >= 0 && m_valid && m_idx == 6'(rst_beat)) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                beat_q.delete();
                am_q.delete();
                check("rst_m_valid", m_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_overrun", overrun, 0);
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                if (!busy) done = 1;
            end
        end
        in_valid = 1'b0;
        m_ready  = 1'b1;
        if (!done) check("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("beats_left", beat_q.size(), 0);
        check("argmax_left", am_q.size(), 0);
        if (rst_beat < 0) begin
            check("handshakes", hs_count, N);
            check("argmax_hold", argmax_idx, last_am);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) mw[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_m_valid", m_valid, 0);
        check("reset_m_last", m_last, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_idx", m_idx, 0);
        check("reset_argmax_idx", argmax_idx, 0);
        check("reset_argmax_valid", argmax_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);

        // Ascending ramp -32..31.
        for (int i = 0; i < N; i++) tb_write(i, i - 32);
        run_drain(0, 0, -1);
        check("argmax_ramp", last_am, 63);
        check("overrun_clean1", overrun, 0);

        // Reverse order with a duplicate to address 5.
        for (int i = N - 1; i >= 0; i--) begin
            tb_write(i, i - 32);
            if (i == 5) tb_write(5, 100);
        end
        run_drain(0, 0, -1);
        check("argmax_dup", last_am, 5);

        // All equal, stalling downstream.
        for (int i = 0; i < N; i++) tb_write(i, 7);
        run_drain(1, 0, -1);
        check("argmax_ties", last_am, 0);
        check("overrun_clean2", overrun, 0);

        // Writes during drain and on the last handshake are dropped.
        for (int i = 0; i < N; i++) tb_write(i, int'($signed(16'($urandom))));
        run_drain(0, 1, -1);
        check("overrun_set", overrun, 1);
        for (int i = 0; i < N; i++) tb_write(N - 1 - i, int'($signed(16'($urandom))));
        run_drain(1, 0, -1);
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of a drain, then a fresh frame.
        for (int i = 0; i < N; i++) tb_write(i, 3 * i - 50);
        run_drain(0, 0, 20);
        for (int i = 0; i < N; i++) tb_write(i, int'($signed(16'($urandom))));
        run_drain(0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
